rr_bus_arbiter_4: RTL

- Round-robin arbiter and sequencer for a 4-source shared tristate bus; each source's buffer enable comes from a 2-to-4 one-hot decode of the owner index.
- Grants one requester at a time, enforces a hold limit when others are waiting, and inserts one dead (turnaround) cycle between owners so two tristate drivers are never enabled together.
- Sits between the bus requesters and the decoder/tristate-buffer mux datapath.

---
 rtl/rr_bus_arbiter_4.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rr_bus_arbiter_4.sv
// Round-robin arbiter for a 4-source shared tristate bus.
// It grants one owner at a time, forces rotation after a hold limit, and inserts a dead cycle between owners.
module rr_bus_arbiter_4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  output logic [3:0]       gnt,
  output logic [1:0]       gnt_idx,
  output logic             bus_en,
  output logic             busy,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_t           state, state_nx;
  logic [1:0]       last, last_nx;
  logic [3:0]       gnt_nx;
  logic [1:0]       gnt_idx_nx;
  logic             bus_en_nx;
  logic             busy_nx;
  logic [CNT_W-1:0] hold_cnt_nx;
  logic [1:0]       winner;
  logic             others_waiting;

  // Search ascending from last+1 with wrap; the loop runs from the farthest
  // offset down, so the nearest set bit is the one that remains.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] c;
    pick = l;
    for (int i = 4; i >= 1; i--) begin
      c = l + 2'(i);
      if (r[c]) begin
        pick = c;
      end
    end
  endfunction

  function automatic logic [3:0] decode(input logic [1:0] idx);
    decode = 4'b0001 << idx;
  endfunction

  assign winner         = pick(req, last);
  assign others_waiting = (req & ~gnt) != 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      last     <= 2'd3;
      gnt      <= 4'b0000;
      gnt_idx  <= 2'd0;
      bus_en   <= 1'b0;
      busy     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      last     <= last_nx;
      gnt      <= gnt_nx;
      gnt_idx  <= gnt_idx_nx;
      bus_en   <= bus_en_nx;
      busy     <= busy_nx;
      hold_cnt <= hold_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    last_nx     = last;
    gnt_nx      = gnt;
    gnt_idx_nx  = gnt_idx;
    bus_en_nx   = bus_en;
    busy_nx     = busy;
    hold_cnt_nx = hold_cnt;
    case (state)
      ST_IDLE, ST_TURN: begin
        if (req != 4'b0000) begin
          state_nx    = ST_GRANT;
          gnt_nx      = decode(winner);
          gnt_idx_nx  = winner;
          bus_en_nx   = 1'b1;
          busy_nx     = 1'b1;
          hold_cnt_nx = CNT_W'(1);
        end else begin
          state_nx    = ST_IDLE;
          gnt_nx      = 4'b0000;
          bus_en_nx   = 1'b0;
          busy_nx     = 1'b0;
          hold_cnt_nx = '0;
        end
      end
      ST_GRANT: begin
        // A release and a hold expiry on the same cycle leave identical outputs.
        if (!req[gnt_idx] || (hold_cnt == HOLD_MAX && others_waiting)) begin
          state_nx    = ST_TURN;
          last_nx     = gnt_idx;
          gnt_nx      = 4'b0000;
          bus_en_nx   = 1'b0;
          busy_nx     = 1'b1;
          hold_cnt_nx = '0;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt_nx = hold_cnt + CNT_W'(1);
        end else begin
          hold_cnt_nx = hold_cnt;
        end
      end
      default: begin
        state_nx    = ST_IDLE;
        gnt_nx      = 4'b0000;
        bus_en_nx   = 1'b0;
        busy_nx     = 1'b0;
        hold_cnt_nx = '0;
      end
    endcase
  end

endmodule
